// File: rtl/ldtu_pkg.sv
// Shared types, constants and helper functions for the LiteDTU output-stream frame checker.
package ldtu_pkg;

  localparam int unsigned Nbits_32   = 32;
  localparam int unsigned crcBits    = 12;
  localparam int unsigned FrameWords = 50;
  localparam int unsigned CntBits    = 16;
  localparam int unsigned NwBits     = 6;

  localparam logic [NwBits-1:0]  FrameWordsN = NwBits'(FrameWords);
  localparam logic [3:0]         HDR_IDLE    = 4'hF;
  localparam logic [3:0]         HDR_TRAILER = 4'hD;
  // x^12 + x^11 + x^3 + x^2 + x + 1, implicit x^12 term dropped
  localparam logic [crcBits-1:0] CrcPoly     = 12'h80F;

  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_SYNC} state_e;

  // Word is shifted in MSB first, matching the transmit-side serial order.
  function automatic logic [crcBits-1:0] crc12_next(input logic [Nbits_32-1:0] data,
                                                    input logic [crcBits-1:0]  crc);
    logic [crcBits-1:0] c;
    logic               fb;
    c = crc;
    for (int i = Nbits_32 - 1; i >= 0; i--) begin
      fb = c[crcBits-1] ^ data[i];
      c  = {c[crcBits-2:0], 1'b0} ^ (fb ? CrcPoly : '0);
    end
    return c;
  endfunction

  // Only meaningful for data headers (bits [7:6] != 2'b11).
  function automatic logic [7:0] sample_count(input logic [7:0] hdr);
    logic [7:0] n;
    if (hdr[7:6] == 2'b01) begin
      n = 8'd5;
    end else if (hdr[7:6] == 2'b10) begin
      n = {2'b00, hdr[5:0]};
    end else if (hdr[7:2] == 6'b001010) begin
      n = 8'd2;
    end else begin
      n = 8'd1;
    end
    return n;
  endfunction

  function automatic logic [CntBits-1:0] sat_inc(input logic [CntBits-1:0] v);
    return (&v) ? v : v + CntBits'(1);
  endfunction

endpackage

// File: rtl/ldtu_frame_checker_if.sv
// Word-stream input and check-result outputs of the frame checker.
interface ldtu_frame_checker_if;
  import ldtu_pkg::*;

  logic                word_valid;
  logic [Nbits_32-1:0] word_in;
  logic                frame_done;
  logic                frame_ok;
  logic                crc_err;
  logic                nsamp_err;
  logic                nframe_err;
  logic                len_err;
  logic                proto_err;
  logic [7:0]          frame_id;
  logic [CntBits-1:0]  ok_cnt;
  logic [CntBits-1:0]  err_cnt;

  modport master (
    output word_valid, word_in,
    input  frame_done, frame_ok, crc_err, nsamp_err, nframe_err, len_err, proto_err,
    input  frame_id, ok_cnt, err_cnt
  );

  modport slave (
    input  word_valid, word_in,
    output frame_done, frame_ok, crc_err, nsamp_err, nframe_err, len_err, proto_err,
    output frame_id, ok_cnt, err_cnt
  );

endinterface

// File: rtl/ldtu_frame_acc.sv
// Per-frame accumulator: running CRC-12, sample count (mod 256) and data-word count.
module ldtu_frame_acc
  import ldtu_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clr,
  input  logic                i_en,
  input  logic [Nbits_32-1:0] i_word,
  output logic [crcBits-1:0]  o_crc,
  output logic [7:0]          o_nsamp,
  output logic [NwBits-1:0]   o_nwords
);

  logic [crcBits-1:0] r_crc;
  logic [7:0]         r_nsamp;
  logic [NwBits-1:0]  r_nwords;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_crc    <= '0;
      r_nsamp  <= '0;
      r_nwords <= '0;
    end else if (i_en) begin
      r_crc    <= crc12_next(i_word, r_crc);
      r_nsamp  <= r_nsamp + sample_count(i_word[31:24]);
      r_nwords <= r_nwords + NwBits'(1);
    end
  end

  assign o_crc    = r_crc;
  assign o_nsamp  = r_nsamp;
  assign o_nwords = r_nwords;

endmodule

// File: rtl/ldtu_frame_checker.sv
// LiteDTU receive-side frame checker: classifies output words, checks each trailer against
// the accumulated CRC / sample count / frame number, and keeps saturating pass/fail counts.
module ldtu_frame_checker
  import ldtu_pkg::*;
(
  input  logic                CLK_,
  input  logic                reset_,
  input  logic                fallback_,
  ldtu_frame_checker_if.slave bus
);

  state_e             r_state;
  logic               r_frame_done, r_frame_ok, r_crc_err, r_nsamp_err, r_nframe_err;
  logic               r_len_err, r_proto_err;
  logic [7:0]         r_frame_id, r_exp_frame;
  logic [CntBits-1:0] r_ok_cnt, r_err_cnt;

  logic [7:0]         w_hdr;
  logic               w_take, w_is_idle, w_is_trl, w_is_data, w_is_proto, w_full;
  logic               w_acc_en, w_acc_clr;
  logic               w_crc_bad, w_ns_bad, w_nf_bad, w_short, w_bad;
  logic [crcBits-1:0] w_crc;
  logic [7:0]         w_nsamp;
  logic [NwBits-1:0]  w_nwords;

  assign w_hdr      = bus.word_in[31:24];
  assign w_take     = bus.word_valid && !fallback_;
  assign w_is_idle  = w_hdr[7:4] == HDR_IDLE;
  assign w_is_trl   = w_hdr[7:4] == HDR_TRAILER;
  assign w_is_data  = w_hdr[7:6] != 2'b11;
  assign w_is_proto = !w_is_data && !w_is_idle && !w_is_trl;
  assign w_full     = w_nwords == FrameWordsN;

  // A trailer always closes the frame, whatever state it arrives in.
  assign w_acc_en  = w_take && w_is_data && !w_full && (r_state != S_SYNC);
  assign w_acc_clr = fallback_ || (w_take && w_is_trl);

  assign w_crc_bad = bus.word_in[19:8] != w_crc;
  assign w_ns_bad  = bus.word_in[27:20] != w_nsamp;
  assign w_nf_bad  = bus.word_in[7:0] != r_exp_frame;
  assign w_short   = (w_nwords != '0) && !w_full;
  assign w_bad     = w_crc_bad || w_ns_bad || w_nf_bad || w_short;

  ldtu_frame_acc u_acc (
    .i_clk    (CLK_),
    .i_rst_n  (reset_),
    .i_clr    (w_acc_clr),
    .i_en     (w_acc_en),
    .i_word   (bus.word_in),
    .o_crc    (w_crc),
    .o_nsamp  (w_nsamp),
    .o_nwords (w_nwords)
  );

  always_ff @(posedge CLK_) begin
    if (!reset_) begin
      r_state      <= S_IDLE;
      r_frame_done <= 1'b0;
      r_frame_ok   <= 1'b0;
      r_crc_err    <= 1'b0;
      r_nsamp_err  <= 1'b0;
      r_nframe_err <= 1'b0;
      r_len_err    <= 1'b0;
      r_proto_err  <= 1'b0;
      r_frame_id   <= '0;
      r_exp_frame  <= '0;
      r_ok_cnt     <= '0;
      r_err_cnt    <= '0;
    end else begin
      r_frame_done <= 1'b0;
      r_frame_ok   <= 1'b0;
      r_crc_err    <= 1'b0;
      r_nsamp_err  <= 1'b0;
      r_nframe_err <= 1'b0;
      r_len_err    <= 1'b0;
      r_proto_err  <= 1'b0;
      if (fallback_) begin
        r_state <= S_IDLE;
      end else if (bus.word_valid && !w_is_idle) begin
        unique case (r_state)
          S_SYNC: begin
            if (w_is_trl) begin
              r_exp_frame <= bus.word_in[7:0] + 8'd1;
              r_state     <= S_IDLE;
            end
          end
          S_IDLE, S_FRAME: begin
            if (w_is_trl) begin
              r_frame_done <= 1'b1;
              r_frame_ok   <= !w_bad;
              r_crc_err    <= w_crc_bad;
              r_nsamp_err  <= w_ns_bad;
              r_nframe_err <= w_nf_bad;
              r_len_err    <= w_short;
              if (w_bad) r_err_cnt <= sat_inc(r_err_cnt);
              else       r_ok_cnt  <= sat_inc(r_ok_cnt);
              r_frame_id   <= bus.word_in[7:0];
              r_exp_frame  <= bus.word_in[7:0] + 8'd1;
              r_state      <= S_IDLE;
            end else if (w_is_proto) begin
              r_proto_err <= 1'b1;
              r_err_cnt   <= sat_inc(r_err_cnt);
              r_state     <= S_SYNC;
            end else if (w_full) begin
              r_len_err <= 1'b1;
              r_err_cnt <= sat_inc(r_err_cnt);
              r_state   <= S_SYNC;
            end else begin
              r_state <= S_FRAME;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.frame_done = r_frame_done;
  assign bus.frame_ok   = r_frame_ok;
  assign bus.crc_err    = r_crc_err;
  assign bus.nsamp_err  = r_nsamp_err;
  assign bus.nframe_err = r_nframe_err;
  assign bus.len_err    = r_len_err;
  assign bus.proto_err  = r_proto_err;
  assign bus.frame_id   = r_frame_id;
  assign bus.ok_cnt     = r_ok_cnt;
  assign bus.err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_ldtu_frame_checker.sv
// Scoreboard bench for ldtu_frame_checker: a frame-level reference model queues the expected
// result of every word; a negedge monitor pops and compares whenever the DUT pulses.
module tb_ldtu_frame_checker;
  import ldtu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fb = 1'b0;
  always #5 clk = ~clk;

  ldtu_frame_checker_if bus ();

  ldtu_frame_checker dut (
    .CLK_      (clk),
    .reset_    (rst_n),
    .fallback_ (fb),
    .bus       (bus)
  );

  typedef struct packed {
    logic        done, ok, crc, ns, nf, len, proto;
    logic [7:0]  id;
    logic [15:0] okc, errc;
  } obs_t;

  obs_t        exp_q[$];
  logic [31:0] m_words[$];
  bit          m_sync;
  logic [7:0]  m_exp, m_id;
  int          m_ok, m_err;
  int          checks = 0;
  int          failures = 0;
  bit          chk_zero = 0;
  bit          stim_done = 0;

  // CRC as polynomial remainder of (crc * x^32 + word * x^12) mod P, folded over the frame.
  function automatic logic [11:0] ref_crc();
    logic [11:0] r;
    logic [43:0] v;
    r = '0;
    foreach (m_words[k]) begin
      v = {r, 32'b0} ^ {m_words[k], 12'b0};
      for (int i = 43; i >= 12; i--) begin
        if (v[i]) v = v ^ (44'(13'h180F) << (i - 12));
      end
      r = v[11:0];
    end
    return r;
  endfunction

  function automatic int ref_ns(input logic [7:0] h);
    case (h[7:6])
      2'b01:   return 5;
      2'b10:   return int'(h[5:0]);
      default: return (h[7:2] == 6'b001010) ? 2 : 1;
    endcase
  endfunction

  function automatic logic [31:0] good_trailer(input logic [7:0] nf);
    int ns;
    ns = 0;
    foreach (m_words[k]) ns += ref_ns(m_words[k][31:24]);
    return {4'hD, 8'(ns), ref_crc(), nf};
  endfunction

  function automatic logic [31:0] rand_data();
    logic [7:0] h;
    case ($urandom_range(0, 3))
      0:       h = {2'b01, 6'($urandom)};
      1:       h = {2'b10, 6'($urandom)};
      2:       h = {2'b00, 6'($urandom)};
      default: h = 8'h28;
    endcase
    return {h, 24'($urandom)};
  endfunction

  task automatic model_reset();
    m_words.delete();
    m_sync = 0;
    m_exp  = '0;
    m_id   = '0;
    m_ok   = 0;
    m_err  = 0;
  endtask

  task automatic model_word(input logic [31:0] w);
    obs_t e;
    int   ns;
    e = '0;
    if (w[31:28] == 4'hF) return;
    if (m_sync) begin
      if (w[31:28] == 4'hD) begin
        m_exp  = w[7:0] + 8'd1;
        m_sync = 0;
        m_words.delete();
      end
      return;
    end
    if (w[31:28] == 4'hD) begin
      ns = 0;
      foreach (m_words[k]) ns += ref_ns(m_words[k][31:24]);
      e.done = 1'b1;
      e.crc  = w[19:8] != ref_crc();
      e.ns   = w[27:20] != 8'(ns % 256);
      e.nf   = w[7:0] != m_exp;
      e.len  = (m_words.size() != 0) && (m_words.size() != FrameWords);
      e.ok   = !(e.crc || e.ns || e.nf || e.len);
      if (e.ok) m_ok = (m_ok < 65535) ? m_ok + 1 : m_ok;
      else      m_err = (m_err < 65535) ? m_err + 1 : m_err;
      m_id  = w[7:0];
      m_exp = w[7:0] + 8'd1;
      m_words.delete();
    end else if (w[31:30] == 2'b11) begin
      e.proto = 1'b1;
      m_err   = (m_err < 65535) ? m_err + 1 : m_err;
      m_sync  = 1;
    end else if (m_words.size() == FrameWords) begin
      e.len  = 1'b1;
      m_err  = (m_err < 65535) ? m_err + 1 : m_err;
      m_sync = 1;
    end else begin
      m_words.push_back(w);
      return;
    end
    e.id   = m_id;
    e.okc  = 16'(m_ok);
    e.errc = 16'(m_err);
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [31:0] w);
    bus.word_valid = 1'b1;
    bus.word_in    = w;
    if (!fb) model_word(w);
    @(posedge clk);
    #1;
    bus.word_valid = 1'b0;
    bus.word_in    = $urandom;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fb    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_zero = 1;
    @(negedge clk);
    #1 chk_zero = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send_frame(input int n, input bit const_words);
    for (int i = 0; i < n; i++) send(const_words ? 32'h4000_0000 : rand_data());
  endtask

  initial begin : stimulus
    logic [31:0] t;
    int          kind, n;
    bus.word_valid = 1'b0;
    bus.word_in    = '0;
    do_reset();

    // Constant-header frames: good, CRC bit 8 flipped, good again.
    send_frame(50, 1);
    send(good_trailer(m_exp));
    send_frame(50, 1);
    send(good_trailer(m_exp) ^ 32'h0000_0100);
    send_frame(50, 1);
    send(good_trailer(m_exp));

    // 25 x 10-sample and 25 x 2-sample words, shuffled; trailer NSamples off by one.
    begin
      int a, b;
      a = 0;
      b = 0;
      for (int i = 0; i < 50; i++) begin
        if (b == 25 || (a < 25 && $urandom_range(0, 1) == 0)) begin
          send(32'h8A00_0000);
          a++;
        end else begin
          send(32'h2800_0000);
          b++;
        end
      end
      t = good_trailer(m_exp);
      t[27:20] = t[27:20] + 8'd1;
      send(t);
    end

    // Overlong frame, resync trailer, then a clean frame.
    send_frame(51, 0);
    send(good_trailer(m_exp));
    send_frame(50, 0);
    send(good_trailer(m_exp));

    // Empty frame right after reset, undefined header, resync, clean frame.
    gap(2);
    do_reset();
    send(32'hD000_0000);
    send(32'hC000_0000);
    send(32'hD000_0005);
    send_frame(50, 0);
    send(good_trailer(m_exp));

    // Fallback in mid-frame, then a fresh frame.
    send_frame(20, 0);
    fb = 1'b1;
    m_words.delete();
    m_sync = 0;
    for (int i = 0; i < 10; i++) send(rand_data());
    fb = 1'b0;
    send_frame(50, 0);
    send(good_trailer(m_exp));

    // Frame-number wrap 0xFF -> 0x00.
    send(32'hD000_00FE);
    send_frame(50, 0);
    send(good_trailer(m_exp));
    send_frame(50, 0);
    send(good_trailer(m_exp));

    // Random traffic: mostly full frames, some short/empty/overlong, idle words and errors.
    for (int f = 0; f < 24; f++) begin
      kind = $urandom_range(0, 9);
      n = (kind < 6) ? 50 : (kind == 6) ? $urandom_range(1, 49) : (kind == 7) ? 0 : 51;
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 7) == 0) send({4'hF, 28'($urandom)});
        send(rand_data());
      end
      if (kind == 8) send({2'b11, 1'($urandom), 1'b0, 28'($urandom)});
      t = good_trailer(m_exp);
      if ($urandom_range(0, 3) == 0) t = t ^ (32'd1 << $urandom_range(0, 27));
      send(t);
      if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 3));
    end

    gap(4);
    stim_done = 1;
  end

  initial begin : monitor
    obs_t got, e;
    int   cyc;
    cyc = 0;
    while (!stim_done && cyc < 50000) begin
      @(negedge clk);
      cyc++;
      got = {bus.frame_done, bus.frame_ok, bus.crc_err, bus.nsamp_err, bus.nframe_err,
             bus.len_err, bus.proto_err, bus.frame_id, bus.ok_cnt, bus.err_cnt};
      if (chk_zero) begin
        checks++;
        if (got !== '0) begin
          failures++;
          $display("FAIL reset_state got=%h required=0", got);
        end
      end
      if (bus.frame_done || bus.len_err || bus.proto_err) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event t=%0t got=%h required=none", $time, got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL event t=%0t got=%h required=%h", $time, got, e);
          end
        end
      end
    end
    if (!stim_done) begin
      checks++;
      failures++;
      $display("FAIL timeout got=%0d cycles required=stimulus complete", cyc);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events got=%0d pending required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
